// File: rtl/gpio_ports_if.sv
// gpio_ports_if: CPU IO bus between the SoC address decode (master) and the GPIO block (slave)
interface gpio_ports_if #(
  parameter int ADDR_BITS = 8
);
  logic                 sel;
  logic [ADDR_BITS-1:0] io_addr;
  logic [3:0]           wmask;
  logic [31:0]          wdata;
  logic                 rstrb;
  logic [31:0]          rdata;
  logic                 rbusy;
  logic                 wbusy;
  modport master (output sel, io_addr, wmask, wdata, rstrb, input rdata, rbusy, wbusy);
  modport slave (input sel, io_addr, wmask, wdata, rstrb, output rdata, rbusy, wbusy);
endinterface

// File: rtl/gpio_ports.sv
// gpio_ports: memory-mapped GPIO ports with rising-edge capture and interrupt; define GPIO_TOGGLE_REG_EN to add the write-only TOGGLE register at offset 5
module gpio_ports #(
  parameter int NUM_PORTS  = 2,
  parameter int PORT_WIDTH = 8,
  parameter int ADDR_BITS  = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  gpio_ports_if.slave                     bus,
  output logic                            irq,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] port_out,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] port_dir,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0] port_in
);
  localparam int N = NUM_PORTS * PORT_WIDTH;
  logic [N-1:0]           s1, s2, s3, status, mask, rise;
  logic [1:0]             warm;
  logic [ADDR_BITS-4:0]   pidx;
  logic [2:0]             off;
  logic [31:0]            bm;
  logic [PORT_WIDTH-1:0]  wm, wd, rsel;
  logic [NUM_PORTS-1:0]   hit;
  logic                   irq_d, unused_ok;
  assign pidx = bus.io_addr[ADDR_BITS-1:3];
  assign off = bus.io_addr[2:0];
  assign bm = {{8{bus.wmask[3]}}, {8{bus.wmask[2]}}, {8{bus.wmask[1]}}, {8{bus.wmask[0]}}};
  assign wm = bm[PORT_WIDTH-1:0];
  assign wd = bus.wdata[PORT_WIDTH-1:0] & wm;
  assign rise = warm == 2'd0 ? s2 & ~s3 : '0;
  assign bus.rbusy = 1'b0;
  assign bus.wbusy = 1'b0;
  assign unused_ok = ^{bus.wdata, bm};
  // Per-port write select, read mux of the addressed register and interrupt reduction
  always_comb begin
    hit = '0;
    rsel = '0;
    irq_d = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      hit[p] = bus.sel && (bus.wmask != 4'd0) && pidx == (ADDR_BITS-3)'(p);
      irq_d = irq_d | (|(status[p*PORT_WIDTH +: PORT_WIDTH] & mask[p*PORT_WIDTH +: PORT_WIDTH]));
      if (pidx == (ADDR_BITS-3)'(p))
        rsel = off == 3'd0 ? port_out[p*PORT_WIDTH +: PORT_WIDTH] :
               off == 3'd1 ? port_dir[p*PORT_WIDTH +: PORT_WIDTH] :
               off == 3'd2 ? s2[p*PORT_WIDTH +: PORT_WIDTH] :
               off == 3'd3 ? status[p*PORT_WIDTH +: PORT_WIDTH] :
               off == 3'd4 ? mask[p*PORT_WIDTH +: PORT_WIDTH] : '0;
    end
  end
  // Register file, input synchroniser, warm-up counter, registered read data and interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      port_out <= '0;
      port_dir <= '0;
      mask <= '0;
      status <= '0;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      warm <= 2'd3;
      bus.rdata <= '0;
      irq <= 1'b0;
    end else begin
      s1 <= port_in;
      s2 <= s1;
      s3 <= s2;
      warm <= warm - {1'b0, warm != 2'd0};
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (hit[p] && off == 3'd0)
          port_out[p*PORT_WIDTH +: PORT_WIDTH] <= (port_out[p*PORT_WIDTH +: PORT_WIDTH] & ~wm) | wd;
`ifdef GPIO_TOGGLE_REG_EN
        if (hit[p] && off == 3'd5)
          port_out[p*PORT_WIDTH +: PORT_WIDTH] <= port_out[p*PORT_WIDTH +: PORT_WIDTH] ^ wd;
`endif
        if (hit[p] && off == 3'd1)
          port_dir[p*PORT_WIDTH +: PORT_WIDTH] <= (port_dir[p*PORT_WIDTH +: PORT_WIDTH] & ~wm) | wd;
        if (hit[p] && off == 3'd4)
          mask[p*PORT_WIDTH +: PORT_WIDTH] <= (mask[p*PORT_WIDTH +: PORT_WIDTH] & ~wm) | wd;
        status[p*PORT_WIDTH +: PORT_WIDTH] <= (status[p*PORT_WIDTH +: PORT_WIDTH] &
          ~((hit[p] && off == 3'd3) ? wd : '0)) | rise[p*PORT_WIDTH +: PORT_WIDTH];
      end
      if (bus.sel && bus.rstrb) bus.rdata <= 32'(rsel);
      irq <= irq_d;
    end
  end
endmodule

// File: tb/tb_gpio_ports.sv
// tb_gpio_ports: randomized scoreboard bench for gpio_ports against a register-level reference model
module tb_gpio_ports;
  localparam int NP = 2;
  localparam int W = 8;
  localparam int AB = 8;
  localparam int N = NP * W;
  localparam logic [31:0] PM = 32'((64'd1 << W) - 1);
  typedef struct {
    logic [N-1:0] out;
    logic [N-1:0] dir;
    logic         irq;
    logic [31:0]  rd;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic irq;
  logic [N-1:0] port_out, port_dir, port_in;
  gpio_ports_if #(.ADDR_BITS(AB)) bus();
  gpio_ports #(.NUM_PORTS(NP), .PORT_WIDTH(W), .ADDR_BITS(AB)) dut (
    .clk(clk), .reset(reset), .bus(bus), .irq(irq),
    .port_out(port_out), .port_dir(port_dir), .port_in(port_in)
  );
  always #5 clk = ~clk;
  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;
  logic [31:0] m_out[NP], m_dir[NP], m_st[NP], m_mask[NP];
  logic [N-1:0] ph0, ph1, ph2;
  int since;
  logic m_irq;
  logic [31:0] m_rd;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] x);
    compared++;
    if (a !== x) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", n, a, x);
    end
  endfunction

  // monitor: every cycle the DUT presents state that the model predicted
  always @(negedge clk) begin : mon
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("port_out", 32'(port_out), 32'(e.out));
      chk("port_dir", 32'(port_dir), 32'(e.dir));
      chk("irq", 32'(irq), 32'(e.irq));
      chk("rdata", bus.rdata, e.rd);
    end
  end

  task automatic step();
    exp_t e;
    int p, o;
    logic [31:0] bm, mw, rv;
    logic [N-1:0] rise;
    logic ni;
    bit wr;
    if (reset) begin
      for (int q = 0; q < NP; q++) begin
        m_out[q] = 0; m_dir[q] = 0; m_st[q] = 0; m_mask[q] = 0;
      end
      ph0 = '0; ph1 = '0; ph2 = '0;
      since = 0; m_irq = 1'b0; m_rd = 0;
    end else begin
      p = int'(bus.io_addr) / 8;
      o = int'(bus.io_addr) % 8;
      bm = {{8{bus.wmask[3]}}, {8{bus.wmask[2]}}, {8{bus.wmask[1]}}, {8{bus.wmask[0]}}};
      mw = bus.wdata & bm & PM;
      rise = since >= 3 ? ph1 & ~ph2 : '0;
      rv = 0;
      if (p < NP)
        case (o)
          0: rv = m_out[p];
          1: rv = m_dir[p];
          2: rv = 32'(ph1[p*W +: W]);
          3: rv = m_st[p];
          4: rv = m_mask[p];
          default: rv = 0;
        endcase
      ni = 1'b0;
      for (int q = 0; q < NP; q++) ni |= |(m_st[q] & m_mask[q]);
      if (bus.sel && bus.rstrb) m_rd = rv;
      wr = bus.sel && bus.wmask != 4'd0 && p < NP;
      if (wr && o == 3) m_st[p] &= ~mw;
      for (int q = 0; q < NP; q++) m_st[q] |= 32'(rise[q*W +: W]);
      if (wr && o == 0) m_out[p] = (m_out[p] & ~bm) | mw;
      if (wr && o == 1) m_dir[p] = (m_dir[p] & ~bm) | mw;
      if (wr && o == 4) m_mask[p] = (m_mask[p] & ~bm) | mw;
`ifdef GPIO_TOGGLE_REG_EN
      if (wr && o == 5) m_out[p] ^= mw;
`endif
      m_irq = ni;
      ph2 = ph1; ph1 = ph0; ph0 = port_in;
      since++;
    end
    e.out = '0; e.dir = '0;
    for (int q = 0; q < NP; q++) begin
      e.out[q*W +: W] = m_out[q][W-1:0];
      e.dir[q*W +: W] = m_dir[q][W-1:0];
    end
    e.irq = m_irq;
    e.rd = m_rd;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic s, input logic [AB-1:0] a, input logic [3:0] m,
                    input logic [31:0] d, input logic r);
    bus.sel = s; bus.io_addr = a; bus.wmask = m; bus.wdata = d; bus.rstrb = r;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, '0, 4'd0, 0, 1'b0);
  endtask

  initial begin
    port_in = '0;
    bus.sel = 0; bus.io_addr = '0; bus.wmask = '0; bus.wdata = '0; bus.rstrb = 0;
    idle(2);
    reset = 1'b0;
    op(1, 8'h00, 4'b0001, 32'hA5, 0);
    op(1, 8'h00, 4'b0000, 0, 1);
    idle(1);
    op(1, 8'h09, 4'b0001, 32'h1234, 0);
    op(1, 8'h09, 4'b0000, 0, 1);
    idle(1);
    op(1, 8'h04, 4'b0001, 32'h01, 0);
    port_in[0] = 1'b1;
    idle(4);
    op(1, 8'h03, 4'b0000, 0, 1);
    op(1, 8'h03, 4'b0001, 32'h01, 1);
    idle(3);
    port_in = '0;
    idle(3);
    reset = 1'b1;
    port_in[0] = 1'b1;
    idle(1);
    reset = 1'b0;
    op(1, 8'h04, 4'b0001, 32'hFF, 0);
    idle(6);
    op(1, 8'h03, 4'b0000, 0, 1);
    op(1, 8'h02, 4'b0000, 0, 1);
    op(1, 8'h00, 4'b1111, 32'h5A, 0);
    op(1, 8'h20, 4'b1111, 32'hFF, 1);
    op(1, 8'h06, 4'b1111, 32'hFF, 1);
    op(1, 8'h00, 4'b0000, 0, 1);
    op(1, 8'h00, 4'b0001, 32'h0F, 0);
    op(1, 8'h05, 4'b0001, 32'hFF, 1);
    op(1, 8'h00, 4'b0000, 0, 1);
    idle(1);
    repeat (800) begin
      if ($urandom_range(0, 7) == 0) port_in = N'($urandom);
      reset = $urandom_range(0, 149) == 0;
      op($urandom_range(0, 3) != 0, AB'($urandom_range(0, 31)), 4'($urandom),
         $urandom, $urandom_range(0, 1) == 1);
    end
    reset = 1'b0;
    idle(3);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/gpio_ports.md
Name: gpio_ports

Overview:
Memory-mapped, parametrised GPIO block replacing the single hard-wired LED output register in the SoC IO decode. It provides NUM_PORTS ports of PORT_WIDTH bits, each with:
- an output register
- a direction register
- a synchronised input readback
- rising-edge capture with a write-1-to-clear status register
- an interrupt mask

All ports combine into one registered interrupt_request to the CPU. The block sits on the CPU memory bus behind the IO address select.

Parameters:
NUM_PORTS, 2, number of GPIO ports (1..32).
PORT_WIDTH, 8, bits per port (1..32).
ADDR_BITS, 8, width of io word address; register word index = port*8 + offset.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
sel  in  1  IO region selected (address decode from SoC).
io_addr  in  ADDR_BITS  IO word address.
wmask  in  4  byte write mask; write occurs when sel && wmask!=0.
wdata  in  32  write data.
rstrb  in  1  read strobe.
rdata  out  32  read data, registered.
rbusy  out  1  read busy; constant 0.
wbusy  out  1  write busy; constant 0.
irq  out  1  registered interrupt request.
port_out  out  NUM_PORTS*PORT_WIDTH  output register values; port p occupies bits [p*PORT_WIDTH +: PORT_WIDTH].
port_dir  out  NUM_PORTS*PORT_WIDTH  1 = pin driven as output.
port_in  in  NUM_PORTS*PORT_WIDTH  asynchronous pin inputs.

Behaviour:
Reset state (reset high at a clk edge):
- port_out, port_dir, MASK, STATUS, rdata, irq, synchroniser and edge flops all = 0.
- Warm-up counter is loaded with 3.

Register map, per port, by word offset:
- 0 OUT (RW)
- 1 DIR (RW)
- 2 IN (RO)
- 3 STATUS (RW1C)
- 4 MASK (RW)
- 5 TOGGLE (WO, optional)
- 6..7 reserved

Decode rules:
- Port index = io_addr[ADDR_BITS-1:3]; offset = io_addr[2:0].
- Port index >= NUM_PORTS or a reserved offset: writes ignored, reads return 0.
- Register bits at and above PORT_WIDTH read 0 and are not writable.

Writes:
- Take effect at the clk edge where sel && wmask!=0.
- wmask[n] gates bits [8n+7:8n].
- Writes to IN are ignored.
- STATUS: a 1 in a write-enabled bit clears that bit.

Reads:
- sel && rstrb at edge k loads rdata at edge k; data is valid in cycle k+1 (1-cycle latency, same as RAM).
- rdata holds its value until the next read.
- A simultaneous read and write to the same register returns the pre-write value.

Input path:
- 2-flop synchroniser per bit (s1, s2), plus a delayed copy s3.
- IN reads s2.
- rise = s2 & ~s3.

Warm-up:
- The counter decrements each cycle while non-zero.
- Edge capture is suppressed while it is non-zero, so pins high at reset release produce no spurious STATUS bits.

STATUS update:
- STATUS[b] sets on rise[b].
- If a set and a W1C hit the same bit in the same cycle, set wins.
- Timing: pin rising before edge k gives s2=1 at edge k+1 and STATUS=1 at edge k+2.

Interrupt:
- irq <= OR over all ports of (STATUS & MASK).
- irq is registered, so it asserts one edge after the STATUS bit sets.
- irq deasserts one edge after the last masked bit clears.
- Writing MASK=0 deasserts irq on the next edge.

Reset asserted mid-operation clears all state at that edge regardless of bus activity; bus writes in that cycle are discarded.

Optional Feature:
Macro GPIO_TOGGLE_REG_EN.
- Defined: offset 5 (TOGGLE) is write-only; each write-enabled 1 bit inverts the matching OUT bit at the write edge. Reads of offset 5 return 0. A simultaneous OUT write cannot occur, since there is one bus address per cycle.
- Undefined: offset 5 is reserved; writes are ignored, reads return 0, and no toggle logic is synthesised.

Test Plan:
1. Reset, then write 0xA5 mask 0001 to port 0 OUT (io_addr 0) -> port_out[7:0]=0xA5 after that edge. Read io_addr 0 -> rdata=0x000000A5 next cycle.
2. Write 0x1234 mask 0001 to port 1 DIR (io_addr 9) -> port_dir[15:8]=0x34; other bits unchanged. Read io_addr 9 returns 0x34.
3. Set port 0 MASK=0x01; drive port_in[0] 0->1 before edge k -> STATUS[0]=1 at k+2, irq=1 at k+3. Write 0x01 to io_addr 3 -> STATUS clears, irq=0 one edge later.
4. Drive port_in[0]=1 before reset release with MASK=0xFF -> STATUS stays 0 and irq stays 0 (warm-up suppression).
5. Read io_addr 0x20 (port 4, NUM_PORTS=2) and io_addr 6 -> rdata=0. Writes to these addresses change no register.
6. With GPIO_TOGGLE_REG_EN: OUT=0x0F, write 0xFF to io_addr 5 -> port_out[7:0]=0xF0. Without the macro -> OUT stays 0x0F.
